zaman_yazma_hakemi: RTL and testbench

- Write-port arbiter for the shared time/date field register file inside the clock-update datapath.
- Three requesters compete for the single write port:
  - T: 1 Hz tick incrementer.
  - B: button/switch editor.
  - U: UART command parser.
- T has fixed highest priority. B and U share the port round-robin, and either may lock the port for a multi-field burst (e.g. UART "set full date").
- Sits between the requesters and the field register file; the display path reads the register file directly.

---
 rtl/zaman_pkg.sv | 35 +++
 rtl/rr_hakem_2.sv | 41 ++++
 rtl/zaman_yazma_hakemi.sv | 217 +++++++++++++++++++++
 tb/tb_zaman_yazma_hakemi.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/zaman_pkg.sv
// Shared definitions for the time/date register-file write arbiter.
// Holds the field index map, default widths, owner encoding, FSM state
// constants and the bit positions used by the B/U round-robin pair.
package zaman_pkg;

    // Default widths and limits; the top module takes these as parameter defaults.
    localparam int FIELD_DW     = 8;
    localparam int FIELD_AW     = 3;
    localparam int LOCK_MAX_DEF = 8;

    // Field indices inside the time/date register file.
    localparam logic [2:0] ALAN_SANIYE = 3'd0;
    localparam logic [2:0] ALAN_DAKIKA = 3'd1;
    localparam logic [2:0] ALAN_SAAT   = 3'd2;
    localparam logic [2:0] ALAN_GUN    = 3'd3;
    localparam logic [2:0] ALAN_AY     = 3'd4;
    localparam logic [2:0] ALAN_YIL    = 3'd5;

    // Number of valid fields: anything at or above this index is rejected.
    localparam int NFIELD = int'(ALAN_YIL) + 1;

    // Lock owner encoding as seen on the owner output.
    localparam logic [1:0] OWNER_NONE = 2'd0;
    localparam logic [1:0] OWNER_B    = 2'd2;
    localparam logic [1:0] OWNER_U    = 2'd3;

    // Arbiter FSM states.
    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    // Bit positions of B and U in the round-robin request/grant vectors.
    localparam int RR_B = 0;
    localparam int RR_U = 1;

endpackage

// File: rtl/rr_hakem_2.sv
// Two-way round-robin picker for the B/U requester pair.
// Ports:
//   CLK    - system clock
//   reset  - asynchronous active-low reset (pointer returns to favour B)
//   req    - request vector, bit RR_B = B, bit RR_U = U
//   gnt    - combinational one-hot pick (zero when no request)
// The pointer moves to the other requester whenever a pick is made, so the
// caller gates req to zero in cycles where this picker must not win.
module rr_hakem_2
    import zaman_pkg::*;
(
    input  logic       CLK,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr_q;
    logic ptr_d;

    // ptr_q = 0 favours B, 1 favours U.
    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (!ptr_q) begin
            if (req[RR_B])      gnt[RR_B] = 1'b1;
            else if (req[RR_U]) gnt[RR_U] = 1'b1;
        end else begin
            if (req[RR_U])      gnt[RR_U] = 1'b1;
            else if (req[RR_B]) gnt[RR_B] = 1'b1;
        end
        // After a B pick favour U next, after a U pick favour B.
        if (gnt != 2'b00) ptr_d = gnt[RR_B];
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) ptr_q <= 1'b0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/zaman_yazma_hakemi.sv
// Write-port arbiter for the shared time/date field register file.
// Requesters: T (1 Hz tick, fixed top priority), B (button editor) and
// U (UART parser). B and U share round-robin and may lock the port for a
// multi-field burst; a lock is forcibly released after LOCK_MAX grants.
// Ports:
//   CLK, reset                      - clock, asynchronous active-low reset
//   t/b/u_req, _addr, _data         - write requests, held until granted
//   b_lock, u_lock                  - burst ownership request, sampled with req
//   t/b/u_gnt                       - one-cycle grant pulse (write happens then)
//   wr_en, wr_addr, wr_data         - register-file write port
//   owner                           - lock owner (0 none, 2 B, 3 U)
//   addr_err                        - granted write targeted a non-existent field
//   lock_timeout                    - lock forcibly released at LOCK_MAX grants
module zaman_yazma_hakemi #(
    parameter int DW       = zaman_pkg::FIELD_DW,
    parameter int AW       = zaman_pkg::FIELD_AW,
    parameter int NFIELD   = zaman_pkg::NFIELD,
    parameter int LOCK_MAX = zaman_pkg::LOCK_MAX_DEF
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          t_req,
    input  logic          b_req,
    input  logic          u_req,
    input  logic [AW-1:0] t_addr,
    input  logic [AW-1:0] b_addr,
    input  logic [AW-1:0] u_addr,
    input  logic [DW-1:0] t_data,
    input  logic [DW-1:0] b_data,
    input  logic [DW-1:0] u_data,
    input  logic          b_lock,
    input  logic          u_lock,
    output logic          t_gnt,
    output logic          b_gnt,
    output logic          u_gnt,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic [1:0]    owner,
    output logic          addr_err,
    output logic          lock_timeout
);
    import zaman_pkg::*;

    localparam int CW = $clog2(LOCK_MAX + 1);

    logic          t_gnt_q, b_gnt_q, u_gnt_q;
    logic          t_gnt_d, b_gnt_d, u_gnt_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic [1:0]    owner_q, owner_d;
    logic          addr_err_q, addr_err_d;
    logic          lock_timeout_q, lock_timeout_d;
    logic          state_q, state_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          b_blk_q, b_blk_d;
    logic          u_blk_q, u_blk_d;

    logic          b_is_owner, u_is_owner;
    logic          t_elig, b_elig, u_elig;
    logic [1:0]    rr_req, rr_gnt;
    logic          pick_t, pick_b, pick_u, any_pick;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic          owner_req, owner_lock;

    // A requester granted this cycle sits out one edge, except the lock
    // owner, which streams back-to-back.
    assign b_is_owner = (state_q == ST_LOCKED) && (owner_q == OWNER_B);
    assign u_is_owner = (state_q == ST_LOCKED) && (owner_q == OWNER_U);
    assign t_elig     = t_req && !t_gnt_q;
    assign b_elig     = b_req && (!b_gnt_q || b_is_owner);
    assign u_elig     = u_req && (!u_gnt_q || u_is_owner);

    // The round-robin only arbitrates when no lock is held and T is not
    // taking the port, so its pointer moves only on unlocked-path grants.
    assign rr_req = (state_q == ST_IDLE && !t_elig) ? {u_elig, b_elig} : 2'b00;

    rr_hakem_2 u_rr (
        .CLK   (CLK),
        .reset (reset),
        .req   (rr_req),
        .gnt   (rr_gnt)
    );

    // Grant selection and registered write-port values.
    always_comb begin
        pick_t = t_elig;
        pick_b = 1'b0;
        pick_u = 1'b0;
        if (!t_elig) begin
            if (state_q == ST_LOCKED) begin
                pick_b = b_is_owner && b_elig;
                pick_u = u_is_owner && u_elig;
            end else begin
                pick_b = rr_gnt[RR_B];
                pick_u = rr_gnt[RR_U];
            end
        end
        any_pick = pick_t || pick_b || pick_u;

        sel_addr = '0;
        sel_data = '0;
        if (pick_t) begin
            sel_addr = t_addr;
            sel_data = t_data;
        end else if (pick_b) begin
            sel_addr = b_addr;
            sel_data = b_data;
        end else if (pick_u) begin
            sel_addr = u_addr;
            sel_data = u_data;
        end

        t_gnt_d    = pick_t;
        b_gnt_d    = pick_b;
        u_gnt_d    = pick_u;
        // Out-of-range fields still complete the handshake but never write.
        wr_en_d    = any_pick && (int'(sel_addr) < NFIELD);
        addr_err_d = any_pick && (int'(sel_addr) >= NFIELD);
        wr_addr_d  = sel_addr;
        wr_data_d  = sel_data;
    end

    // Lock FSM. A forced release blocks that requester's lock input until
    // it has been seen low once, so it cannot immediately relock.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        lock_cnt_d     = lock_cnt_q;
        lock_timeout_d = 1'b0;
        b_blk_d        = b_blk_q && b_lock;
        u_blk_d        = u_blk_q && u_lock;
        owner_req      = b_is_owner ? b_req  : u_req;
        owner_lock     = b_is_owner ? b_lock : u_lock;

        case (state_q)
            ST_IDLE: begin
                if (pick_b && b_lock && !b_blk_q) begin
                    state_d    = ST_LOCKED;
                    owner_d    = OWNER_B;
                    lock_cnt_d = CW'(1);
                end else if (pick_u && u_lock && !u_blk_q) begin
                    state_d    = ST_LOCKED;
                    owner_d    = OWNER_U;
                    lock_cnt_d = CW'(1);
                end
            end
            default: begin
                if (!owner_req) begin
                    state_d    = ST_IDLE;
                    owner_d    = OWNER_NONE;
                    lock_cnt_d = '0;
                end else if (pick_b || pick_u) begin
                    if (lock_cnt_q == CW'(LOCK_MAX - 1)) begin
                        lock_timeout_d = 1'b1;
                        state_d        = ST_IDLE;
                        owner_d        = OWNER_NONE;
                        lock_cnt_d     = '0;
                        if (b_is_owner) b_blk_d = b_lock;
                        else            u_blk_d = u_lock;
                    end else if (!owner_lock) begin
                        state_d    = ST_IDLE;
                        owner_d    = OWNER_NONE;
                        lock_cnt_d = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + CW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            t_gnt_q        <= 1'b0;
            b_gnt_q        <= 1'b0;
            u_gnt_q        <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            owner_q        <= OWNER_NONE;
            addr_err_q     <= 1'b0;
            lock_timeout_q <= 1'b0;
            state_q        <= ST_IDLE;
            lock_cnt_q     <= '0;
            b_blk_q        <= 1'b0;
            u_blk_q        <= 1'b0;
        end else begin
            t_gnt_q        <= t_gnt_d;
            b_gnt_q        <= b_gnt_d;
            u_gnt_q        <= u_gnt_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            owner_q        <= owner_d;
            addr_err_q     <= addr_err_d;
            lock_timeout_q <= lock_timeout_d;
            state_q        <= state_d;
            lock_cnt_q     <= lock_cnt_d;
            b_blk_q        <= b_blk_d;
            u_blk_q        <= u_blk_d;
        end
    end

    assign t_gnt        = t_gnt_q;
    assign b_gnt        = b_gnt_q;
    assign u_gnt        = u_gnt_q;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign owner        = owner_q;
    assign addr_err     = addr_err_q;
    assign lock_timeout = lock_timeout_q;

endmodule

// File: tb/tb_zaman_yazma_hakemi.sv
// Scoreboard testbench for zaman_yazma_hakemi: the stimulus process pushes
// the hand-computed grant it expects for each request, and a monitor pops
// and compares on every cycle where the arbiter presents a grant.
module tb_zaman_yazma_hakemi;
    import zaman_pkg::*;

    localparam logic [2:0] G_T = 3'b100;
    localparam logic [2:0] G_B = 3'b010;
    localparam logic [2:0] G_U = 3'b001;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic       t_req = 1'b0, b_req = 1'b0, u_req = 1'b0;
    logic [2:0] t_addr = '0, b_addr = '0, u_addr = '0;
    logic [7:0] t_data = '0, b_data = '0, u_data = '0;
    logic       b_lock = 1'b0, u_lock = 1'b0;
    logic       t_gnt, b_gnt, u_gnt, wr_en, addr_err, lock_timeout;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] owner;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [2:0] gnt;
        logic       we;
        logic [2:0] addr;
        logic [7:0] data;
        logic [1:0] own;
        logic       err;
        logic       to;
    } exp_t;

    exp_t exp_q[$];

    zaman_yazma_hakemi dut (
        .CLK          (CLK),
        .reset        (reset),
        .t_req        (t_req),
        .b_req        (b_req),
        .u_req        (u_req),
        .t_addr       (t_addr),
        .b_addr       (b_addr),
        .u_addr       (u_addr),
        .t_data       (t_data),
        .b_data       (b_data),
        .u_data       (u_data),
        .b_lock       (b_lock),
        .u_lock       (u_lock),
        .t_gnt        (t_gnt),
        .b_gnt        (b_gnt),
        .u_gnt        (u_gnt),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .owner        (owner),
        .addr_err     (addr_err),
        .lock_timeout (lock_timeout)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Let n active edges pass, then return just after the last one.
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic expectGrant(input logic [2:0] gnt, input logic we, input logic [2:0] addr,
                               input logic [7:0] data, input logic [1:0] own,
                               input logic err, input logic to);
        exp_t e;
        e.gnt = gnt; e.we = we; e.addr = addr; e.data = data;
        e.own = own; e.err = err; e.to = to;
        exp_q.push_back(e);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_gnt"},     {29'd0, t_gnt, b_gnt, u_gnt}, 32'd0);
        checkOutput({tag, "_wr_en"},   {31'd0, wr_en}, 32'd0);
        checkOutput({tag, "_wr_addr"}, {29'd0, wr_addr}, 32'd0);
        checkOutput({tag, "_wr_data"}, {24'd0, wr_data}, 32'd0);
        checkOutput({tag, "_owner"},   {30'd0, owner}, 32'd0);
        checkOutput({tag, "_err_to"},  {30'd0, addr_err, lock_timeout}, 32'd0);
    endtask

    // Monitor: any grant-related activity must match the oldest expectation.
    always @(negedge CLK) begin
        if (reset && (t_gnt || b_gnt || u_gnt || wr_en || addr_err || lock_timeout)) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_grant", {29'd0, t_gnt, b_gnt, u_gnt}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("gnt_vector",   {29'd0, t_gnt, b_gnt, u_gnt}, {29'd0, e.gnt});
                checkOutput("wr_en",        {31'd0, wr_en}, {31'd0, e.we});
                checkOutput("addr_err",     {31'd0, addr_err}, {31'd0, e.err});
                checkOutput("lock_timeout", {31'd0, lock_timeout}, {31'd0, e.to});
                checkOutput("owner",        {30'd0, owner}, {30'd0, e.own});
                if (e.we) begin
                    checkOutput("wr_addr", {29'd0, wr_addr}, {29'd0, e.addr});
                    checkOutput("wr_data", {24'd0, wr_data}, {24'd0, e.data});
                end
            end
        end
    end

    initial begin
        // Reset state.
        #8;
        checkAllZero("reset");
        #4 reset = 1'b1;
        applyStimulus(1);

        // Single B request, then a single U request (pointer back to B).
        b_req = 1'b1; b_addr = ALAN_DAKIKA; b_data = 8'h2A;
        expectGrant(G_B, 1'b1, 3'd1, 8'h2A, OWNER_NONE, 1'b0, 1'b0);
        applyStimulus(1);
        b_req = 1'b0;
        u_req = 1'b1; u_addr = ALAN_SANIYE; u_data = 8'h11;
        expectGrant(G_U, 1'b1, 3'd0, 8'h11, OWNER_NONE, 1'b0, 1'b0);
        applyStimulus(1);
        u_req = 1'b0;
        applyStimulus(1);

        // Three-way contention: T, then B, then U on consecutive cycles.
        t_req = 1'b1; t_addr = ALAN_SANIYE; t_data = 8'h05;
        b_req = 1'b1; b_addr = ALAN_SAAT;   b_data = 8'h12;
        u_req = 1'b1; u_addr = ALAN_DAKIKA; u_data = 8'h34;
        expectGrant(G_T, 1'b1, 3'd0, 8'h05, OWNER_NONE, 1'b0, 1'b0);
        expectGrant(G_B, 1'b1, 3'd2, 8'h12, OWNER_NONE, 1'b0, 1'b0);
        expectGrant(G_U, 1'b1, 3'd1, 8'h34, OWNER_NONE, 1'b0, 1'b0);
        applyStimulus(1);
        t_req = 1'b0;
        applyStimulus(1);
        b_req = 1'b0;
        applyStimulus(1);
        u_req = 1'b0;
        applyStimulus(1);

        // UART burst to day/month/year while B waits.
        u_req = 1'b1; u_lock = 1'b1; u_addr = ALAN_GUN; u_data = 8'h0F;
        expectGrant(G_U, 1'b1, 3'd3, 8'h0F, OWNER_U, 1'b0, 1'b0);
        applyStimulus(1);
        u_addr = ALAN_AY; u_data = 8'h08;
        b_req = 1'b1; b_addr = ALAN_SAAT; b_data = 8'h55;
        expectGrant(G_U, 1'b1, 3'd4, 8'h08, OWNER_U, 1'b0, 1'b0);
        applyStimulus(1);
        u_addr = ALAN_YIL; u_data = 8'h19; u_lock = 1'b0;
        expectGrant(G_U, 1'b1, 3'd5, 8'h19, OWNER_NONE, 1'b0, 1'b0);
        applyStimulus(1);
        u_req = 1'b0;
        expectGrant(G_B, 1'b1, 3'd2, 8'h55, OWNER_NONE, 1'b0, 1'b0);
        applyStimulus(1);
        b_req = 1'b0;
        applyStimulus(1);

        // Locked U burst with a tick in the middle; forced release on the
        // 8th U grant, B served next, U relock ignored until lock goes low.
        u_req = 1'b1; u_lock = 1'b1; u_addr = 3'd0; u_data = 8'h30;
        b_req = 1'b1; b_addr = 3'd1; b_data = 8'h77;
        expectGrant(G_U, 1'b1, 3'd0, 8'h30, OWNER_U, 1'b0, 1'b0);
        applyStimulus(1);
        u_addr = 3'd1; u_data = 8'h31;
        expectGrant(G_U, 1'b1, 3'd1, 8'h31, OWNER_U, 1'b0, 1'b0);
        applyStimulus(1);
        u_addr = 3'd2; u_data = 8'h32;
        t_req = 1'b1; t_addr = 3'd0; t_data = 8'h01;
        expectGrant(G_T, 1'b1, 3'd0, 8'h01, OWNER_U, 1'b0, 1'b0);
        applyStimulus(1);
        t_req = 1'b0;
        expectGrant(G_U, 1'b1, 3'd2, 8'h32, OWNER_U, 1'b0, 1'b0);
        applyStimulus(1);
        for (int k = 4; k <= 8; k++) begin
            u_addr = 3'((k - 1) % 6);
            u_data = 8'(8'h2F + k);
            expectGrant(G_U, 1'b1, 3'((k - 1) % 6), 8'(8'h2F + k),
                        (k == 8) ? OWNER_NONE : OWNER_U, 1'b0, (k == 8));
            applyStimulus(1);
        end
        u_addr = 3'd2; u_data = 8'h38;
        expectGrant(G_B, 1'b1, 3'd1, 8'h77, OWNER_NONE, 1'b0, 1'b0);
        applyStimulus(1);
        b_req = 1'b0;
        expectGrant(G_U, 1'b1, 3'd2, 8'h38, OWNER_NONE, 1'b0, 1'b0);
        applyStimulus(1);
        u_addr = 3'd3; u_data = 8'h39;
        applyStimulus(1);
        expectGrant(G_U, 1'b1, 3'd3, 8'h39, OWNER_NONE, 1'b0, 1'b0);
        applyStimulus(1);
        u_req = 1'b0; u_lock = 1'b0;
        applyStimulus(1);

        // Relock after re-arm, then an out-of-range field.
        u_req = 1'b1; u_lock = 1'b1; u_addr = 3'd2; u_data = 8'h44;
        expectGrant(G_U, 1'b1, 3'd2, 8'h44, OWNER_U, 1'b0, 1'b0);
        applyStimulus(1);
        u_addr = 3'd7; u_data = 8'h99;
        expectGrant(G_U, 1'b0, 3'd7, 8'h99, OWNER_U, 1'b1, 1'b0);
        applyStimulus(1);
        u_addr = 3'd4; u_data = 8'h66; u_lock = 1'b0;

        // Asynchronous reset mid-burst, after the monitor has seen the grant.
        #5 reset = 1'b0;
        #1 checkAllZero("async_reset");
        expectGrant(G_U, 1'b1, 3'd4, 8'h66, OWNER_NONE, 1'b0, 1'b0);
        @(negedge CLK);
        reset = 1'b1;
        applyStimulus(1);
        u_req = 1'b0;
        applyStimulus(3);

        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
